// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses, synchronous flush and optional first-word-fall-through.
module sync_fifo_flex #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned ADDR_WIDTH    = $clog2(DEPTH),
  parameter int unsigned AFULL_THRESH  = DEPTH - 4,
  parameter int unsigned AEMPTY_THRESH = 4,
  parameter bit          FWFT          = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  rd_en_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  rvalid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  typedef logic [ADDR_WIDTH:0] ptr_t;

  localparam ptr_t AFULL_C  = ptr_t'(AFULL_THRESH);
  localparam ptr_t AEMPTY_C = ptr_t'(AEMPTY_THRESH);

  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  ptr_t             count;
  logic             full, empty;
  logic             wr_acc, rd_acc;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Flags come only from the registered pointers, so no input reaches them combinationally.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                 (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign wr_acc = wr_en_i && !full  && !clr_i;
  assign rd_acc = rd_en_i && !empty && !clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ptr_t'(1);
      ovf_d = wr_en_i && full;
      udf_d = rd_en_i && empty;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wdata_i;
  end

  generate
    if (FWFT) begin : g_fwft
      // Head is masked to zero while empty so the stale array never shows on rdata_o.
      assign rdata_o  = empty ? '0 : mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
      assign rvalid_o = !empty;
    end else begin : g_std
      logic [WIDTH-1:0] rdata_q;
      logic             rvalid_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= rd_acc;
          if (rd_acc) rdata_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
      end

      assign rdata_o  = rdata_q;
      assign rvalid_o = rvalid_q;
    end
  endgenerate

  assign count_o        = count;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count >= AFULL_C);
  assign almost_empty_o = (count <= AEMPTY_C);
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: a registered-read and an FWFT instance share stimulus and
// are checked against a queue-based reference model plus directed vector tables.
module tb_sync_fifo_flex;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, wr, rd;
  logic [7:0] wd;

  logic [7:0] rdata0, rdata1;
  logic       rvalid0, rvalid1, full0, full1, empty0, empty1;
  logic       af0, af1, ae0, ae1, ov0, ov1, un0, un1;
  logic [4:0] count0, count1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .FWFT(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .wr_en_i(wr), .wdata_i(wd), .rd_en_i(rd),
    .rdata_o(rdata0), .rvalid_o(rvalid0), .full_o(full0), .empty_o(empty0),
    .almost_full_o(af0), .almost_empty_o(ae0), .count_o(count0),
    .overflow_o(ov0), .underflow_o(un0));

  sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .FWFT(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .wr_en_i(wr), .wdata_i(wd), .rd_en_i(rd),
    .rdata_o(rdata1), .rvalid_o(rvalid1), .full_o(full1), .empty_o(empty1),
    .almost_full_o(af1), .almost_empty_o(ae1), .count_o(count1),
    .overflow_o(ov1), .underflow_o(un1));

  // Reference model: contents as a queue, registered-read outputs as plain variables.
  logic [7:0] mq[$];
  logic [7:0] m_rdata0;
  logic       m_rvalid0, m_ov, m_un;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdata0  = 8'h00;
    m_rvalid0 = 1'b0;
    m_ov      = 1'b0;
    m_un      = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic w, input logic r, input logic [7:0] d);
    int unsigned n = mq.size();
    if (c) begin
      mq.delete();
      m_ov = 1'b0; m_un = 1'b0; m_rvalid0 = 1'b0;
    end else begin
      m_ov      = w && (n == 16);
      m_un      = r && (n == 0);
      m_rvalid0 = r && (n != 0);
      if (m_rvalid0) m_rdata0 = mq.pop_front();
      if (w && (n != 16)) mq.push_back(d);
    end
  endtask

  task automatic compare_model();
    int unsigned n = mq.size();
    check("count0",  count0,  n);
    check("count1",  count1,  n);
    check("full0",   full0,   n == 16);
    check("full1",   full1,   n == 16);
    check("empty0",  empty0,  n == 0);
    check("empty1",  empty1,  n == 0);
    check("afull",   af0,     n >= 12);
    check("aempty",  ae0,     n <= 4);
    check("afull1",  af1,     n >= 12);
    check("aempty1", ae1,     n <= 4);
    check("ovf0",    ov0,     m_ov);
    check("udf0",    un0,     m_un);
    check("ovf1",    ov1,     m_ov);
    check("udf1",    un1,     m_un);
    check("rvalid0", rvalid0, m_rvalid0);
    check("rdata0",  rdata0,  m_rdata0);
    check("rvalid1", rvalid1, n != 0);
    check("rdata1",  rdata1,  (n != 0) ? mq[0] : 8'h00);
  endtask

  task automatic step(input logic c, input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    clr = c; wr = w; rd = r; wd = d;
    @(posedge clk);
    model_step(c, w, r, d);
    #1;
    compare_model();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"},  count0,  5'd0);
    check({tag, "_empty"},  empty0,  1'b1);
    check({tag, "_aempty"}, ae0,     1'b1);
    check({tag, "_full"},   full0,   1'b0);
    check({tag, "_afull"},  af0,     1'b0);
    check({tag, "_rdata0"}, rdata0,  8'h00);
    check({tag, "_rvalid0"},rvalid0, 1'b0);
    check({tag, "_ovf"},    ov0,     1'b0);
    check({tag, "_udf"},    un0,     1'b0);
    check({tag, "_rdata1"}, rdata1,  8'h00);
    check({tag, "_rvalid1"},rvalid1, 1'b0);
  endtask

  typedef struct {
    logic       clr, wr, rd;
    logic [7:0] wdata;
    logic [4:0] exp_count;
    logic       exp_ov, exp_un, exp_rvalid0;
    logic [7:0] exp_rdata0;
  } vec_t;

  vec_t tv[36];

  initial begin
    int k = 0;
    for (int i = 0; i < 16; i++)
      tv[k++] = '{1'b0, 1'b1, 1'b0, 8'(i), 5'(i + 1), 1'b0, 1'b0, 1'b0, 8'h00};
    tv[k++] = '{1'b0, 1'b1, 1'b0, 8'hAA, 5'd16, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[k++] = '{1'b0, 1'b1, 1'b1, 8'h55, 5'd15, 1'b1, 1'b0, 1'b1, 8'h00};
    for (int i = 1; i < 16; i++)
      tv[k++] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'(15 - i), 1'b0, 1'b0, 1'b1, 8'(i)};
    tv[k++] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 8'h0F};
    tv[k++] = '{1'b0, 1'b1, 1'b1, 8'h77, 5'd1, 1'b0, 1'b1, 1'b0, 8'h0F};
    tv[k++] = '{1'b1, 1'b1, 1'b0, 8'h99, 5'd0, 1'b0, 1'b0, 1'b0, 8'h0F};

    rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; wd = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill, overflow, full wr+rd, drain, underflow, empty wr+rd, flush with write.
    for (int i = 0; i < 36; i++) begin
      step(tv[i].clr, tv[i].wr, tv[i].rd, tv[i].wdata);
      check($sformatf("tv%0d_count", i),  count0,  tv[i].exp_count);
      check($sformatf("tv%0d_ovf", i),    ov0,     tv[i].exp_ov);
      check($sformatf("tv%0d_udf", i),    un0,     tv[i].exp_un);
      check($sformatf("tv%0d_rvalid", i), rvalid0, tv[i].exp_rvalid0);
      check($sformatf("tv%0d_rdata", i),  rdata0,  tv[i].exp_rdata0);
      if (i == 11) check("afull_at_12", af0, 1'b1);
      if (i == 10) check("afull_at_11", af0, 1'b0);
    end

    // Wrap-around at a steady occupancy of 8: 40 writes wrap both pointers twice.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'(8 + i));
      check("wrap_count", count0, 5'd8);
      check("wrap_rdata", rdata0, 8'(i));
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("wrap_drain", rdata0, 8'(32 + i));
    end
    check("wrap_empty", empty0, 1'b1);

    // FWFT: word shows up the cycle after the write with no read request.
    step(1'b0, 1'b1, 1'b0, 8'h3C);
    check("fwft_rvalid", rvalid1, 1'b1);
    check("fwft_rdata",  rdata1,  8'h3C);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("fwft_pop_rvalid", rvalid1, 1'b0);
    check("fwft_pop_empty",  empty1,  1'b1);

    // Flush together with a write: no overflow, FIFO empty.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
    step(1'b1, 1'b1, 1'b0, 8'hEE);
    check("clr_count", count0, 5'd0);
    check("clr_empty", empty0, 1'b1);
    check("clr_ovf",   ov0,    1'b0);

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hA1 + i));
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("pre_reset_rdata", rdata0, 8'hA1);
    @(negedge clk);
    clr = 1'b0; wr = 1'b0; rd = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("async");
    @(posedge clk);
    #1;
    check_reset_values("held");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic with drifting write/read bias and occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      int unsigned pw, pr;
      logic c, w, r;
      pw = 20 + ((i / 200) % 4) * 20;
      pr = 80 - ((i / 200) % 4) * 20;
      c = ($urandom_range(63) == 0);
      w = ($urandom_range(99) < pw);
      r = ($urandom_range(99) < pr);
      step(c, w, r, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
